// File: rtl/wbtimer.sv
// Wishbone slave timer: 8-bit prescaler, 32-bit counter with compare/match and level irq.
// Optional input capture unit enabled by defining WBTIMER_CAPTURE_EN.
module wbtimer #(
    parameter logic [11:0] BASE = 12'd0
) (
    input  logic        clk,
    input  logic        arstn,
    input  logic [14:0] adr_i,
    input  logic [31:0] dat_i,
    output logic [31:0] dat_o,
    input  logic        we_i,
    input  logic        stb_i,
    output logic        ack_o,
    output logic        irq
`ifdef WBTIMER_CAPTURE_EN
    ,
    input  logic        cap_i
`endif
);

    localparam int unsigned DW = 32;
    localparam int unsigned PW = 8;

    localparam logic [2:0] OFF_CTRL    = 3'd0;
    localparam logic [2:0] OFF_COUNT   = 3'd1;
    localparam logic [2:0] OFF_COMPARE = 3'd2;
    localparam logic [2:0] OFF_STATUS  = 3'd3;
    localparam logic [2:0] OFF_CAPTURE = 3'd4;

    logic          ack_q, ack_d;
    logic [DW-1:0] dat_q, dat_d;
    logic          irq_q, irq_d;
    logic          en_q, en_d;
    logic          reload_q, reload_d;
    logic          irqen_q, irqen_d;
    logic [PW-1:0] pre_q, pre_d;
    logic [PW-1:0] psc_q, psc_d;
    logic [DW-1:0] count_q, count_d;
    logic [DW-1:0] compare_q, compare_d;
    logic          match_q, match_d;
    logic          capf_c;
    logic [DW-1:0] capture_c;

    logic          sel_c;
    logic          wr_c;
    logic          rd_c;
    logic          tick_c;
    logic [DW-1:0] rdata_c;

`ifdef WBTIMER_CAPTURE_EN
    logic [2:0]    sync_q, sync_d;
    logic          capf_q, capf_d;
    logic [DW-1:0] capture_q, capture_d;
    logic          cap_rise_c;
`endif

    assign dat_o = dat_q;
    assign ack_o = ack_q;
    assign irq   = irq_q;

    // A strobe is only taken when no ack is pending, giving one ack per two cycles.
    assign sel_c  = stb_i && (adr_i[14:3] == BASE) && !ack_q;
    assign wr_c   = sel_c && we_i;
    assign rd_c   = sel_c && !we_i;
    assign tick_c = en_q && (psc_q == pre_q);

`ifdef WBTIMER_CAPTURE_EN
    assign cap_rise_c = sync_q[1] && !sync_q[2];
    assign capf_c     = capf_q;
    assign capture_c  = capture_q;
`else
    assign capf_c     = 1'b0;
    assign capture_c  = '0;
`endif

    // Read mux
    always_comb begin
        rdata_c = '0;
        case (adr_i[2:0])
            OFF_CTRL:    rdata_c = {16'd0, pre_q, 5'd0, irqen_q, reload_q, en_q};
            OFF_COUNT:   rdata_c = count_q;
            OFF_COMPARE: rdata_c = compare_q;
            OFF_STATUS:  rdata_c = {30'd0, capf_c, match_q};
            OFF_CAPTURE: rdata_c = capture_c;
            default:     rdata_c = '0;
        endcase
    end

    // Next-state: timer events first, bus writes override, status sets beat clears.
    always_comb begin
        logic match_set;
        logic match_clr;
        ack_d     = sel_c;
        dat_d     = rd_c ? rdata_c : '0;
        en_d      = en_q;
        reload_d  = reload_q;
        irqen_d   = irqen_q;
        pre_d     = pre_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_set = 1'b0;
        match_clr = 1'b0;

        if (!en_q || tick_c) psc_d = '0;
        else                 psc_d = psc_q + PW'(1);

        if (tick_c) begin
            if (count_q == compare_q) begin
                match_set = 1'b1;
                count_d   = reload_q ? '0 : count_q + DW'(1);
            end else begin
                count_d   = count_q + DW'(1);
            end
        end

`ifdef WBTIMER_CAPTURE_EN
        sync_d    = {sync_q[1:0], cap_i};
        capture_d = cap_rise_c ? count_q : capture_q;
        capf_d    = capf_q;
`endif

        if (wr_c) begin
            case (adr_i[2:0])
                OFF_CTRL: begin
                    en_d     = dat_i[0];
                    reload_d = dat_i[1];
                    irqen_d  = dat_i[2];
                    pre_d    = dat_i[15:8];
                end
                OFF_COUNT: begin
                    count_d = dat_i;
                    psc_d   = '0;
                end
                OFF_COMPARE: compare_d = dat_i;
                OFF_STATUS: begin
                    match_clr = dat_i[0];
`ifdef WBTIMER_CAPTURE_EN
                    if (dat_i[1]) capf_d = 1'b0;
`endif
                end
                default: ;
            endcase
        end

        match_d = (match_q && !match_clr) || match_set;
`ifdef WBTIMER_CAPTURE_EN
        if (cap_rise_c) capf_d = 1'b1;
`endif
        irq_d = match_d && irqen_d;
    end

    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            ack_q     <= 1'b0;
            dat_q     <= '0;
            irq_q     <= 1'b0;
            en_q      <= 1'b0;
            reload_q  <= 1'b0;
            irqen_q   <= 1'b0;
            pre_q     <= '0;
            psc_q     <= '0;
            count_q   <= '0;
            compare_q <= '0;
            match_q   <= 1'b0;
        end else begin
            ack_q     <= ack_d;
            dat_q     <= dat_d;
            irq_q     <= irq_d;
            en_q      <= en_d;
            reload_q  <= reload_d;
            irqen_q   <= irqen_d;
            pre_q     <= pre_d;
            psc_q     <= psc_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
        end
    end

`ifdef WBTIMER_CAPTURE_EN
    // Two-flop synchronizer plus one history flop for edge detection
    always_ff @(posedge clk or negedge arstn) begin
        if (!arstn) begin
            sync_q    <= '0;
            capf_q    <= 1'b0;
            capture_q <= '0;
        end else begin
            sync_q    <= sync_d;
            capf_q    <= capf_d;
            capture_q <= capture_d;
        end
    end
`endif

endmodule

// File: tb/tb_wbtimer.sv
// Self-checking bench for wbtimer (BASE=1): expected read data is queued before each
// transfer and popped when the ack arrives.
module tb_wbtimer;

    logic        clk = 1'b0;
    logic        arstn = 1'b1;
    logic [14:0] adr_i = '0;
    logic [31:0] dat_i = '0;
    logic [31:0] dat_o;
    logic        we_i = 1'b0;
    logic        stb_i = 1'b0;
    logic        ack_o;
    logic        irq;
`ifdef WBTIMER_CAPTURE_EN
    logic        cap_i = 1'b0;
`endif

    int          errors = 0;
    int          checks = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd;
    logic [31:0] e;
    int          lat;

    wbtimer #(.BASE(12'd1)) dut (
        .clk   (clk),
        .arstn (arstn),
        .adr_i (adr_i),
        .dat_i (dat_i),
        .dat_o (dat_o),
        .we_i  (we_i),
        .stb_i (stb_i),
        .ack_o (ack_o),
        .irq   (irq)
`ifdef WBTIMER_CAPTURE_EN
        ,
        .cap_i (cap_i)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] ra(input int off);
        return 15'(8 + off);
    endfunction

    // One Wishbone transfer, started and ended on a falling edge, with one idle cycle after.
    task automatic wb(input logic we, input logic [14:0] adr, input logic [31:0] wd,
                      output logic [31:0] rdat, output int l);
        stb_i = 1'b1; we_i = we; adr_i = adr; dat_i = wd; l = 0;
        do begin
            @(posedge clk); @(negedge clk); l++;
        end while (ack_o !== 1'b1 && l < 8);
        rdat = dat_o;
        if (ack_o !== 1'b1) begin
            checks++; errors++;
            $display("FAIL ack_timeout adr=%h: no ack within 8 cycles", adr);
        end
        stb_i = 1'b0; we_i = 1'b0; dat_i = '0;
        @(negedge clk);
    endtask

    task automatic wr(input int off, input logic [31:0] d);
        logic [31:0] dummy;
        int          l;
        wb(1'b1, ra(off), d, dummy, l);
    endtask

    task automatic test_reset;
        @(negedge clk);
        #1 arstn = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({ack_o, irq, dat_o} !== 34'd0) begin
            errors++; $display("FAIL reset_outputs got ack=%b irq=%b dat=%h want 0", ack_o, irq, dat_o);
        end
        arstn = 1'b1;
        @(negedge clk);
        for (int off = 0; off < 8; off++) begin
            exp_q.push_back(32'd0);
            wb(1'b0, ra(off), '0, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL reset_read off=%0d got %h want %h", off, rd, e); end
            checks++;
            if (lat !== 1) begin errors++; $display("FAIL reset_read_latency off=%0d got %0d want 1", off, lat); end
        end
    endtask

    task automatic test_prescaler_match;
        int n;
        wr(2, 32'd9);
        wr(0, 32'h0000_0307);
        n = 0;
        while (irq !== 1'b1 && n < 100) begin @(negedge clk); n++; end
        checks++;
        if (irq !== 1'b1 || (n + 1) < 39 || (n + 1) > 41) begin
            errors++; $display("FAIL match_delay got irq=%b after %0d cycles want 1 after 40", irq, n + 1);
        end
        exp_q.push_back(32'd0);
        wb(1'b0, ra(1), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL reload_count got %h want %h", rd, e); end
        exp_q.push_back(32'd1);
        wb(1'b0, ra(3), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL match_status got %h want %h", rd, e); end
        wr(3, 32'd1);
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL irq_clear got %b want 0", irq); end
        exp_q.push_back(32'd0);
        wb(1'b0, ra(3), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL status_cleared got %h want %h", rd, e); end
        wr(0, 32'd0);
    endtask

    task automatic test_wrap;
        int n;
        wr(3, 32'd3);
        wr(2, 32'd5);
        wr(1, 32'hFFFF_FFFE);
        wr(0, 32'h0000_0005);
        // Reads sample COUNT one and three ticks after enable
        exp_q.push_back(32'hFFFF_FFFF);
        exp_q.push_back(32'h0000_0001);
        for (int i = 0; i < 2; i++) begin
            wb(1'b0, ra(1), '0, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL wrap_count%0d got %h want %h", i, rd, e); end
        end
        checks++;
        if (irq !== 1'b0) begin errors++; $display("FAIL wrap_early_match got irq=%b want 0", irq); end
        n = 0;
        while (irq !== 1'b1 && n < 20) begin @(negedge clk); n++; end
        checks++;
        if (n !== 3) begin errors++; $display("FAIL wrap_match_time got %0d want 3 cycles", n); end
        wr(0, 32'd0);
        wr(3, 32'd1);
    endtask

    task automatic test_contention;
        wr(0, 32'h0000_0001);
        wr(1, 32'h0000_0100);
        exp_q.push_back(32'h0000_0101);
        wb(1'b0, ra(1), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL count_write_on_tick got %h want %h", rd, e); end
        wr(0, 32'h0000_0201);
        wr(1, 32'h0000_0100);
        exp_q.push_back(32'h0000_0100);
        exp_q.push_back(32'h0000_0101);
        for (int i = 0; i < 2; i++) begin
            wb(1'b0, ra(1), '0, rd, lat);
            e = exp_q.pop_front();
            checks++;
            if (rd !== e) begin errors++; $display("FAIL count_write_psc%0d got %h want %h", i, rd, e); end
        end
        wr(0, 32'd0);
        wr(2, 32'h0000_0201);
        wr(3, 32'd3);
        wr(0, 32'h0000_0001);
        wr(1, 32'h0000_0200);
        wr(3, 32'd1);
        exp_q.push_back(32'd1);
        wb(1'b0, ra(3), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL set_beats_clear got %h want %h", rd, e); end
        wr(0, 32'd0);
        wr(3, 32'd1);
    endtask

    task automatic test_decode;
        int acks;
        wr(1, 32'h0000_0055);
        stb_i = 1'b1; we_i = 1'b1; adr_i = 15'h0001; dat_i = 32'hDEAD;
        acks = 0;
        repeat (6) begin @(posedge clk); @(negedge clk); if (ack_o !== 1'b0) acks++; end
        stb_i = 1'b0; we_i = 1'b0;
        @(negedge clk);
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL decode_miss_ack got %0d acks want 0", acks); end
        exp_q.push_back(32'h0000_0055);
        wb(1'b0, 15'h0009, '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL decode_hit_count got %h want %h", rd, e); end
    endtask

`ifdef WBTIMER_CAPTURE_EN
    task automatic test_capture;
        wr(1, 32'h0000_0040);
        cap_i = 1'b1;
        repeat (5) @(negedge clk);
        exp_q.push_back(32'h0000_0040);
        exp_q.push_back(32'h0000_0002);
        wb(1'b0, ra(4), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL capture_value got %h want %h", rd, e); end
        wb(1'b0, ra(3), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL capf_set got %h want %h", rd, e); end
        wr(3, 32'd2);
        exp_q.push_back(32'd0);
        wb(1'b0, ra(3), '0, rd, lat);
        e = exp_q.pop_front();
        checks++;
        if (rd !== e) begin errors++; $display("FAIL capf_clear got %h want %h", rd, e); end
        cap_i = 1'b0;
    endtask
`endif

    task automatic test_reset_abort;
        int acks;
        int n;
        wr(2, 32'h0000_00AA);
        stb_i = 1'b1; we_i = 1'b1; adr_i = ra(2); dat_i = 32'h1234;
        #1 arstn = 1'b0;
        acks = 0;
        repeat (2) begin @(posedge clk); @(negedge clk); if (ack_o !== 1'b0) acks++; end
        checks++;
        if (acks !== 0) begin errors++; $display("FAIL abort_ack got %0d acks want 0", acks); end
        we_i = 1'b0;
        arstn = 1'b1;
        n = 0;
        do begin @(posedge clk); @(negedge clk); n++; end while (ack_o !== 1'b1 && n < 8);
        exp_q.push_back(32'd0);
        e = exp_q.pop_front();
        checks++;
        if (ack_o !== 1'b1 || n !== 1) begin
            errors++; $display("FAIL abort_new_xfer got ack=%b after %0d want 1 after 1", ack_o, n);
        end
        checks++;
        if (dat_o !== e) begin errors++; $display("FAIL abort_compare got %h want %h", dat_o, e); end
        stb_i = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_prescaler_match();
        test_wrap();
        test_contention();
        test_decode();
`ifdef WBTIMER_CAPTURE_EN
        test_capture();
`endif
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
